// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: default widths
// and the starvation-guard state encoding.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned ADDR_W_DEF     = 5;
    localparam int unsigned BUF_DEPTH_DEF  = 2;
    localparam int unsigned STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } starve_state_t;

endpackage

// File: rtl/llu_wb_fifo.sv
// Small synchronous FIFO buffering long-latency-unit results until the
// register-file write port is free. Head is visible while not empty.
module llu_wb_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr];

    // NOTE: storage has no reset; an empty count already makes its contents irrelevant.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between WB (always wins) and
// buffered LLU results; tracks pending LLU destinations and starvation.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned BUF_DEPTH  = BUF_DEPTH_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              llu_valid,
    input  logic [ADDR_W-1:0] llu_waddr,
    input  logic [DATA_W-1:0] llu_wdata,
    output logic              llu_ready,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_waddr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              busy1,
    output logic              busy2,
    output logic              stall_req,
    output logic              err_waw,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned ENT_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic                r_out_en;
    logic [NREG-1:0]     r_pending;
    logic                r_err_waw;
    starve_state_t       r_state;
    starve_state_t       w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_full;
    logic                w_empty;
    logic [ENT_W-1:0]    w_head;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_data;
    logic                w_push;
    logic                w_pop;
    logic                w_iss_set;

    assign {w_head_addr, w_head_data} = w_head;

    // Outputs stay quiet from reset assertion until the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_out_en <= 1'b0;
        else      r_out_en <= 1'b1;
    end

    assign llu_ready = r_out_en && !w_full;
    assign w_push    = llu_valid && llu_ready && (llu_waddr != '0);
    assign w_pop     = r_out_en && !wb_we && !w_empty;
    assign w_iss_set = iss_valid && (iss_waddr != '0);

    llu_wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_din   ({llu_waddr, llu_wdata}),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (r_out_en && wb_we) begin
            rf_we    = 1'b1;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
        end else if (w_pop) begin
            rf_we    = 1'b1;
            rf_waddr = w_head_addr;
            rf_wdata = w_head_data;
        end
    end

    // The set is written after the clear so a same-cycle set on that address wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_err_waw <= 1'b0;
        end else begin
            if (w_pop)     r_pending[w_head_addr] <= 1'b0;
            if (w_iss_set) r_pending[iss_waddr]   <= 1'b1;
            r_err_waw <= (w_iss_set && r_pending[iss_waddr]) ||
                         (wb_we && (wb_waddr != '0) && r_pending[wb_waddr]);
        end
    end

    assign busy1   = (raddr1 != '0) && r_pending[raddr1];
    assign busy2   = (raddr2 != '0) && r_pending[raddr2];
    assign err_waw = r_err_waw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Count of consecutive full-while-WB-busy cycles; the fourth one forces a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_full && wb_we) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!w_full) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (wb_we) begin
                    if (r_cnt == CNT_W'(STARVE_MAX - 1)) w_state_nxt = ST_FORCE;
                    else                                 w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            ST_FORCE: begin
                if (w_pop) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign stall_req = (r_state == ST_FORCE);

endmodule
